// File: rtl/serial_addsub_pkg.sv
// Shared types and parameter helpers for the digit-serial adder/subtractor.
// The top level and its ripple slice both import this package.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Number of digits (RUN cycles) for a given operand width and digit size.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice chained from full-adder cells.
// c_msb is the carry into the slice's top bit, used for overflow detection.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             ci,
  output logic [DIGIT-1:0] s_d,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves a value to be remembered (no latch).
  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      c[i + 1] = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, with
// valid/ready handshakes on the operand and result sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] s_shift;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (opa_q[DIGIT-1:0]),
    .b_d   (opb_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s_d   (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB end; written as a wide shift so DIGIT == WIDTH works.
  assign s_shift = {dig_s, s_q} >> DIGIT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        s_d     = s_shift[WIDTH-1:0];
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          cout_d  = dig_co;
          ovf_d   = dig_cmsb ^ dig_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: an 8-bit/1-digit instance plus 16-bit instances with
// 4-bit and 16-bit digits, checked against an arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, s8;

  logic        in_valid16, cin16, sub16, out_ready16;
  logic [15:0] a16, b16, s16_4, s16_16;
  logic        in_ready16_4, out_valid16_4, cout16_4, ovf16_4;
  logic        in_ready16_16, out_valid16_16, cout16_16, ovf16_16;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16_4 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16_4),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16_4), .out_ready(out_ready16),
    .s(s16_4), .cout(cout16_4), .ovf(ovf16_4)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16_16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16_16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16_16), .out_ready(out_ready16),
    .s(s16_16), .cout(cout16_16), .ovf(ovf16_16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } result_t;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic result_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub);
    result_t r;
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint sa   = (ua >= half) ? ua - (half * 2) : ua;
    longint sb   = (ub >= half) ? ub - (half * 2) : ub;
    longint c    = cin ? 1 : 0;
    longint full, sv;
    if (!sub) begin
      full   = ua + ub + c;
      r.cout = (full > mask);
      sv     = sa + sb + c;
    end else begin
      full   = ua - ub - c;
      r.cout = (full >= 0);
      sv     = sa - sb - c;
    end
    r.s   = 16'(full & mask);
    r.ovf = (sv > half - 1) || (sv < -half);
    return r;
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready8 before accept", in_ready8, 1);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid8 && lat < 50);
  endtask

  task automatic handshake8();
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check("out_valid8 after handshake", out_valid8, 0);
    check("in_ready8 after handshake", in_ready8, 1);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ecout, input logic eovf);
    int lat;
    start8(a, b, cin, sub);
    wait_done8(lat);
    check({name, " latency"}, lat, 8);
    check({name, " s"}, s8, es);
    check({name, " cout"}, cout8, ecout);
    check({name, " ovf"}, ovf8, eovf);
    handshake8();
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    int t = 0;
    int lat4 = 0;
    int lat16 = 0;
    result_t e = model(16, a, b, cin, sub);
    @(negedge clk);
    while (!(in_ready16_4 && in_ready16_16) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, " in_ready16"}, {in_ready16_4, in_ready16_16}, 2'b11);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    for (int i = 1; i <= 20 && (lat4 == 0 || lat16 == 0); i++) begin
      @(posedge clk);
      #1;
      if (out_valid16_4 && lat4 == 0) lat4 = i;
      if (out_valid16_16 && lat16 == 0) lat16 = i;
    end
    check({name, " d4 latency"}, lat4, 4);
    check({name, " d16 latency"}, lat16, 1);
    check({name, " d4 s"}, s16_4, e.s);
    check({name, " d4 cout"}, cout16_4, e.cout);
    check({name, " d4 ovf"}, ovf16_4, e.ovf);
    check({name, " d16 s"}, s16_16, e.s);
    check({name, " d16 cout"}, cout16_16, e.cout);
    check({name, " d16 ovf"}, ovf16_16, e.ovf);
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
    check({name, " out_valid16 cleared"}, {out_valid16_4, out_valid16_16}, 2'b00);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec8_t;

  vec8_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    result_t e;
    logic [7:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    #12;
    check("reset s8", s8, 0);
    check("reset cout8", cout8, 0);
    check("reset ovf8", ovf8, 0);
    check("reset out_valid8", out_valid8, 0);
    check("reset in_ready8", in_ready8, 1);
    check("reset out_valid16", {out_valid16_4, out_valid16_16}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           vecs[i].s, vecs[i].cout, vecs[i].ovf);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      e  = model(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
      run8($sformatf("rand8_%0d", i), ra, rb, rc, rs, e.s[7:0], e.cout, e.ovf);
    end

    // Backpressure: result held, new operands ignored until the handshake.
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done8(lat);
    check("bp latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h22; cin8 = 0; sub8 = 0; in_valid8 = 1'b1;
      @(posedge clk);
      #1;
      check("bp held s", s8, 8'h96);
      check("bp held cout", cout8, 0);
      check("bp held ovf", ovf8, 1);
      check("bp in_ready low", in_ready8, 0);
      check("bp out_valid held", out_valid8, 1);
    end
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    check("bp handshake out_valid", out_valid8, 0);
    check("bp handshake in_ready", in_ready8, 1);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    check("bp second accepted", in_ready8, 0);
    wait_done8(lat);
    check("bp second latency", lat, 8);
    check("bp second s", s8, 8'h33);
    handshake8();

    // Asynchronous reset after three digits of a run.
    start8(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun reset out_valid", out_valid8, 0);
    check("midrun reset s", s8, 0);
    check("midrun reset in_ready", in_ready8, 1);
    @(negedge clk);
    rst = 1'b0;
    run8("after reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Reset while a result is waiting in DONE.
    start8(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done8(lat);
    #2 rst = 1'b1;
    #1;
    check("done reset out_valid", out_valid8, 0);
    check("done reset cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    run8("after done reset", 8'hF0, 8'h0F, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b0);

    run16("w16 7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run16("w16 0-1", 16'h0000, 16'h0001, 1'b0, 1'b1);
    run16("w16 FFFF+1+c", 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      run16($sformatf("rand16_%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
